// File: rtl/multibyte_addsub_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-byte add/subtract sequencer.
//   state_e    : sequencer state encoding (IDLE, RUN, DONE)
//   OP_ADD/SUB : operation select encoding carried on op_sub
//   idx_width  : width of the byte index counter (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // $clog2(1) is 0, so a single-byte sequencer still gets a 1-bit index.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/multibyte_addsub_seq_adder.sv
// -----------------------------------------------------------------------------
// eightBitAdder
// Combinational 8-bit ripple-carry adder shared by the byte sequencer.
// Ports:
//   A, B      : byte operands
//   subtract  : inverts B and forces carry-in (two's-complement subtract)
//   Cin0      : carry into bit 0 (ORed with subtract)
//   sum       : byte result
//   C7        : carry out of bit 7
// -----------------------------------------------------------------------------
module eightBitAdder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       subtract,
    input  logic       Cin0,
    output logic [7:0] sum,
    output logic       C7
);

    logic [7:0] b_x;
    logic [8:0] c;

    always_comb begin
        b_x  = B ^ {8{subtract}};
        c    = '0;
        sum  = '0;
        c[0] = Cin0 | subtract;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = A[i] ^ b_x[i] ^ c[i];
            c[i + 1] = (A[i] & b_x[i]) | (c[i] & (A[i] ^ b_x[i]));
        end
    end

    assign C7 = c[8];

endmodule

// File: rtl/multibyte_addsub_seq.sv
// -----------------------------------------------------------------------------
// multibyte_addsub_seq
// N-byte add/subtract performed one byte per clock, LSB first, through a
// single shared eightBitAdder. Operands are captured on start; the carry (or
// inverted borrow) is held in a register between bytes.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : request an operation (accepted in IDLE or DONE only)
//   op_sub     : 0 = a + b, 1 = a - b (captured with start)
//   a, b       : W-bit operands (captured with start)
//   busy       : high while bytes are being processed
//   done       : one-cycle pulse, result fields valid
//   result     : W-bit sum or difference
//   carry_out  : add: unsigned carry; sub: 1 = no borrow
//   overflow   : signed two's-complement overflow
// -----------------------------------------------------------------------------
module multibyte_addsub_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int                W        = 8 * NBYTES;
    localparam int                IDXW     = idx_width(NBYTES);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NBYTES - 1);

    state_e                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic                       sub_q, sub_d;
    logic [NBYTES-1:0][7:0]     a_q, a_d;
    logic [NBYTES-1:0][7:0]     b_q, b_d;
    logic [NBYTES-1:0][7:0]     res_q, res_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;

    logic       accept;
    logic [7:0] a_byte;
    logic [7:0] b_eff;
    logic [7:0] sum_byte;
    logic       c7;

    // Byte mux feeding the shared adder. The B inversion is done here and the
    // adder's subtract input stays low: its internal OR would otherwise force
    // a carry-in on every byte, not just the first.
    assign a_byte = a_q[idx_q];
    assign b_eff  = b_q[idx_q] ^ {8{sub_q == OP_SUB}};

    eightBitAdder u_adder (
        .A        (a_byte),
        .B        (b_eff),
        .subtract (1'b0),
        .Cin0     (carry_q),
        .sum      (sum_byte),
        .C7       (c7)
    );

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                res_d[idx_q] = sum_byte;
                carry_d      = c7;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c7;
                    // Same-sign operands producing a different-sign result.
                    ovf_d   = (a_byte[7] == b_eff[7]) && (sum_byte[7] != a_byte[7]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture overrides the IDLE/DONE fallthrough, giving back-to-back
        // operation when start arrives in the DONE cycle. The carry register
        // is seeded with 1 on subtract to complete the two's complement.
        if (accept) begin
            a_d     = a;
            b_d     = b;
            sub_d   = op_sub;
            idx_d   = '0;
            carry_d = (op_sub != OP_ADD);
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = W'(res_q);
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multibyte_addsub_seq.sv
module tb_multibyte_addsub_seq;

    localparam int N4 = 4;
    localparam int N1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT with 4-byte operands
    logic        rst4, start4, sub4;
    logic [31:0] a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [31:0] res4;

    // DUT with 1-byte operands
    logic        rst1, start1, sub1;
    logic [7:0]  a1, b1;
    logic        busy1, done1, cout1, ovf1;
    logic [7:0]  res1;

    multibyte_addsub_seq #(.NBYTES(N4)) dut4 (
        .clk(clk), .reset(rst4), .start(start4), .op_sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .carry_out(cout4), .overflow(ovf4)
    );

    multibyte_addsub_seq #(.NBYTES(N1)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .op_sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .carry_out(cout1), .overflow(ovf1)
    );

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   free4 = 0;
    int   free1 = 0;

    // Reference: plain integer arithmetic on w-bit values.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit sub, output logic [63:0] r,
                                  output logic c, output logic v);
        longint unsigned mask, au, bu, full;
        longint          sa, sb, s, lim;
        mask = (64'd1 << w) - 64'd1;
        au   = a & mask;
        bu   = b & mask;
        sa   = au[w-1] ? (longint'(au) - (longint'(1) << w)) : longint'(au);
        sb   = bu[w-1] ? (longint'(bu) - (longint'(1) << w)) : longint'(bu);
        if (sub) begin
            r = (au - bu) & mask;
            c = (au >= bu);
            s = sa - sb;
        end else begin
            full = au + bu;
            r    = full & mask;
            c    = full[w];
            s    = sa + sb;
        end
        lim = longint'(1) << (w - 1);
        v   = (s >= lim) || (s < -lim);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents done.
    exp_t e4, e1;
    always @(posedge clk) begin
        #1;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL dut4_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e4 = q4.pop_front();
                check("dut4_result",  {32'd0, res4}, e4.res);
                check("dut4_carry",   64'(cout4), 64'(e4.cout));
                check("dut4_ovf",     64'(ovf4),  64'(e4.ovf));
                check("dut4_latency", 64'(cyc),   64'(e4.due));
                check("dut4_busy_at_done", 64'(busy4), 64'd0);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_result",  {56'd0, res1}, e1.res);
                check("dut1_carry",   64'(cout1), 64'(e1.cout));
                check("dut1_ovf",     64'(ovf1),  64'(e1.ovf));
                check("dut1_latency", 64'(cyc),   64'(e1.due));
                check("dut1_busy_at_done", 64'(busy1), 64'd0);
            end
        end
    end

    // One driven cycle; a start is expected to be taken only once the
    // previous operation has reached its DONE cycle.
    task automatic step4(input bit s, input bit sub, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic        c, v;
        @(negedge clk);
        start4 = s; sub4 = sub; a4 = a; b4 = b;
        if (s && cyc >= free4) begin
            model(32, {32'd0, a}, {32'd0, b}, sub, r, c, v);
            q4.push_back('{r, c, v, cyc + N4 + 1});
            free4 = cyc + N4 + 1;
        end
    endtask

    task automatic step1(input bit s, input bit sub, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] r;
        logic        c, v;
        @(negedge clk);
        start1 = s; sub1 = sub; a1 = a; b1 = b;
        if (s && cyc >= free1) begin
            model(8, {56'd0, a}, {56'd0, b}, sub, r, c, v);
            q1.push_back('{r, c, v, cyc + N1 + 1});
            free1 = cyc + N1 + 1;
        end
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) step4(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) step1(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy4",   64'(busy4), 64'd0);
        check("reset_done4",   64'(done4), 64'd0);
        check("reset_result4", {32'd0, res4}, 64'd0);
        check("reset_carry4",  64'(cout4), 64'd0);
        check("reset_ovf4",    64'(ovf4),  64'd0);
        check("reset_busy1",   64'(busy1), 64'd0);
        check("reset_result1", {56'd0, res1}, 64'd0);
        rst4 = 1'b0;
        rst1 = 1'b0;

        // Add wrapping to zero with carry.
        step4(1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
        idle4(N4 + 1);
        // Borrow chaining through every byte.
        step4(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001);
        idle4(N4 + 1);

        // Starts during RUN ignored, then a back-to-back start in DONE.
        step4(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0078);
        step4(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        step4(1'b0, 1'b0, 32'h0, 32'h0);
        step4(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        step4(1'b0, 1'b0, 32'h0, 32'h0);
        step4(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001);
        idle4(N4 + 1);

        // Signed overflow cases.
        step4(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        idle4(N4 + 1);
        step4(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
        idle4(N4 + 1);

        // Reset in the second RUN cycle aborts the operation.
        step4(1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222);
        step4(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst4 = 1'b1;
        q4.delete();
        free4 = 0;
        #1;
        check("abort_busy",   64'(busy4), 64'd0);
        check("abort_done",   64'(done4), 64'd0);
        check("abort_result", {32'd0, res4}, 64'd0);
        check("abort_carry",  64'(cout4), 64'd0);
        check("abort_ovf",    64'(ovf4),  64'd0);
        @(negedge clk);
        rst4 = 1'b0;
        idle4(N4 + 2);
        step4(1'b1, 1'b0, 32'h0102_0304, 32'hF0F0_F0F0);
        idle4(N4 + 1);

        // Randomized traffic, including starts that land while busy.
        for (int i = 0; i < 400; i++) begin
            step4(($urandom_range(0, 2) == 0), 1'($urandom), pick(), pick());
        end
        idle4(N4 + 2);

        // Single-byte instance.
        step1(1'b1, 1'b0, 8'hFF, 8'h01);
        idle1(N1 + 1);
        step1(1'b1, 1'b1, 8'h80, 8'h01);
        idle1(N1 + 1);
        for (int i = 0; i < 150; i++) begin
            step1(($urandom_range(0, 1) == 0), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        idle1(N1 + 2);

        // Drain: every expected response must have appeared.
        for (int i = 0; i < 20 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        while (q4.size() != 0) begin
            e4 = q4.pop_front();
            total++; bad++;
            $display("FAIL dut4_missing_done: got none expected result %0h at cycle %0d", e4.res, e4.due);
        end
        while (q1.size() != 0) begin
            e1 = q1.pop_front();
            total++; bad++;
            $display("FAIL dut1_missing_done: got none expected result %0h at cycle %0d", e1.res, e1.due);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
